// File: rtl/pin_mux_cfg_pkg.sv
// Shared definitions for the runtime pin mux: config-port select codes and
// the commit state machine encoding.
package pin_mux_cfg_pkg;

    localparam logic CFG_SEL_PHYS = 1'b0;
    localparam logic CFG_SEL_LOG  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

endpackage

// File: rtl/pin_mux_sync.sv
// Multi-flop synchroniser for a bus of asynchronous pad inputs.
module pin_mux_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the raw pad value through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_r[s] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                stage_r[s] <= stage_r[s-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/pin_mux_cfg.sv
// Runtime pin mux between tester pads and peripheral pins with shadow maps,
// atomic break-before-make commit and a synchronised input path.
module pin_mux_cfg
    import pin_mux_cfg_pkg::*;
#(
    parameter int IO_PHYSICAL = 50,
    parameter int IO_LOGICAL  = 6,
    parameter int MAP_BITS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BBM_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_en,
    input  logic                   cfg_sel,
    input  logic [7:0]             cfg_addr,
    input  logic [MAP_BITS-1:0]    cfg_wdata,
    input  logic                   cfg_commit,
    output logic                   cfg_busy,
    output logic                   cfg_err,
    input  logic [IO_PHYSICAL-1:0] physical_in,
    output logic [IO_PHYSICAL-1:0] physical_val,
    output logic [IO_PHYSICAL-1:0] physical_drive,
    output logic [IO_LOGICAL-1:0]  logical_in,
    input  logic [IO_LOGICAL-1:0]  logical_val,
    input  logic [IO_LOGICAL-1:0]  logical_drive
);

    localparam int PI_W  = (IO_PHYSICAL > 1) ? $clog2(IO_PHYSICAL) : 1;
    localparam int LI_W  = (IO_LOGICAL > 1) ? $clog2(IO_LOGICAL) : 1;
    localparam int CNT_W = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [MAP_BITS-1:0] UNMAPPED     = {MAP_BITS{1'b1}};
    localparam logic [7:0]          PHYS_ADDR_LIM = 8'(IO_PHYSICAL);
    localparam logic [7:0]          LOG_ADDR_LIM  = 8'(IO_LOGICAL);
    localparam logic [MAP_BITS-1:0] PHYS_MAP_LIM  = MAP_BITS'(IO_PHYSICAL);
    localparam logic [MAP_BITS-1:0] LOG_MAP_LIM   = MAP_BITS'(IO_LOGICAL);
    localparam logic [CNT_W-1:0]    BBM_LAST      = CNT_W'(BBM_CYCLES - 1);

    logic [MAP_BITS-1:0] shd_phys_r [IO_PHYSICAL];
    logic [MAP_BITS-1:0] shd_log_r  [IO_LOGICAL];
    logic [MAP_BITS-1:0] act_phys_r [IO_PHYSICAL];
    logic [MAP_BITS-1:0] act_log_r  [IO_LOGICAL];
    logic [MAP_BITS-1:0] src_phys_s [IO_PHYSICAL];
    logic [MAP_BITS-1:0] src_log_s  [IO_LOGICAL];

    state_e                 state_r, state_nx_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
    logic                   wr_phys_s, wr_log_s, err_s, blank_s;
    logic                   cfg_busy_r, cfg_err_r;
    logic [IO_PHYSICAL-1:0] sync_s, pval_nx_s, pdrv_nx_s, pval_r, pdrv_r;
    logic [IO_LOGICAL-1:0]  lin_nx_s, lin_r;

    pin_mux_sync #(.WIDTH(IO_PHYSICAL), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (physical_in),
        .q     (sync_s)
    );

    // Config decode and commit FSM next state; a bad write and a busy commit share one error pulse.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        wr_phys_s  = cfg_wr_en && (cfg_sel == CFG_SEL_PHYS) && (cfg_addr < PHYS_ADDR_LIM);
        wr_log_s   = cfg_wr_en && (cfg_sel == CFG_SEL_LOG) && (cfg_addr < LOG_ADDR_LIM);
        err_s      = (cfg_wr_en && !wr_phys_s && !wr_log_s) ||
                     (cfg_commit && (state_r != ST_IDLE));
        case (state_r)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_nx_s = ST_BREAK;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (cnt_r == BBM_LAST) begin
                    state_nx_s = ST_APPLY;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_APPLY: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
        blank_s = (state_nx_s != ST_IDLE);
    end

    // During APPLY the shadow maps feed the muxes so the new map shows on the first IDLE cycle.
    always_comb begin
        for (int i = 0; i < IO_PHYSICAL; i++) begin
            if (state_r == ST_APPLY) src_phys_s[i] = shd_phys_r[i];
            else                     src_phys_s[i] = act_phys_r[i];
        end
        for (int j = 0; j < IO_LOGICAL; j++) begin
            if (state_r == ST_APPLY) src_log_s[j] = shd_log_r[j];
            else                     src_log_s[j] = act_log_r[j];
        end
    end

    // Next values of both registered mux directions; out-of-range entries read as unmapped.
    always_comb begin
        pval_nx_s = {IO_PHYSICAL{1'b0}};
        pdrv_nx_s = {IO_PHYSICAL{1'b0}};
        lin_nx_s  = {IO_LOGICAL{1'b0}};
        for (int i = 0; i < IO_PHYSICAL; i++) begin
            if (!blank_s && (src_phys_s[i] < LOG_MAP_LIM)) begin
                pval_nx_s[i] = logical_val[src_phys_s[i][LI_W-1:0]];
                pdrv_nx_s[i] = logical_drive[src_phys_s[i][LI_W-1:0]];
            end else begin
                pval_nx_s[i] = 1'b0;
                pdrv_nx_s[i] = 1'b0;
            end
        end
        for (int j = 0; j < IO_LOGICAL; j++) begin
            if (src_log_s[j] < PHYS_MAP_LIM) lin_nx_s[j] = sync_s[src_log_s[j][PI_W-1:0]];
            else                             lin_nx_s[j] = 1'b0;
        end
    end

    // Shadow writes, active-map copy on APPLY, FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IO_PHYSICAL; i++) begin
                shd_phys_r[i] <= UNMAPPED;
                act_phys_r[i] <= UNMAPPED;
            end
            for (int j = 0; j < IO_LOGICAL; j++) begin
                shd_log_r[j] <= UNMAPPED;
                act_log_r[j] <= UNMAPPED;
            end
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            cfg_busy_r <= 1'b0;
            cfg_err_r  <= 1'b0;
            pval_r     <= {IO_PHYSICAL{1'b0}};
            pdrv_r     <= {IO_PHYSICAL{1'b0}};
            lin_r      <= {IO_LOGICAL{1'b0}};
        end else begin
            if (wr_phys_s) shd_phys_r[cfg_addr[PI_W-1:0]] <= cfg_wdata;
            if (wr_log_s)  shd_log_r[cfg_addr[LI_W-1:0]]  <= cfg_wdata;
            if (state_r == ST_APPLY) begin
                act_phys_r <= shd_phys_r;
                act_log_r  <= shd_log_r;
            end
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            cfg_busy_r <= (state_nx_s != ST_IDLE);
            cfg_err_r  <= err_s;
            pval_r     <= pval_nx_s;
            pdrv_r     <= pdrv_nx_s;
            lin_r      <= lin_nx_s;
        end
    end

    assign cfg_busy       = cfg_busy_r;
    assign cfg_err        = cfg_err_r;
    assign physical_val   = pval_r;
    assign physical_drive = pdrv_r;
    assign logical_in     = lin_r;

endmodule

// File: tb/tb_pin_mux_cfg.sv
// Self-checking bench for pin_mux_cfg: table-driven output-path vectors through
// a scoreboard queue plus hand-written commit, error and reset sequences.
module tb_pin_mux_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [7:0]  cfg_addr = 8'd0;
    logic [7:0]  cfg_wdata = 8'd0;
    logic        cfg_commit = 1'b0;
    logic        cfg_busy, cfg_err;
    logic [49:0] physical_in = 50'd0;
    logic [49:0] physical_val, physical_drive;
    logic [5:0]  logical_in;
    logic [5:0]  logical_val = 6'h3F;
    logic [5:0]  logical_drive = 6'h3F;

    int errors = 0;
    int checks = 0;

    localparam logic [49:0] P3_10 = 50'h408;
    localparam logic [49:0] P20   = 50'h10_0000;
    localparam logic [49:0] P49   = 50'h2_0000_0000_0000;

    typedef struct packed {
        logic [5:0]  lv;
        logic [5:0]  ld;
        logic [49:0] exp_val;
        logic [49:0] exp_drv;
    } vec_t;

    typedef struct packed {
        logic [49:0] val;
        logic [49:0] drv;
    } exp_t;

    vec_t vecs [6];
    exp_t sb_q [$];

    pin_mux_cfg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_sel        (cfg_sel),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_commit     (cfg_commit),
        .cfg_busy       (cfg_busy),
        .cfg_err        (cfg_err),
        .physical_in    (physical_in),
        .physical_val   (physical_val),
        .physical_drive (physical_drive),
        .logical_in     (logical_in),
        .logical_val    (logical_val),
        .logical_drive  (logical_drive)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] addr, input logic [7:0] data);
        cfg_wr_en = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 16 && cfg_busy; k++) tick();
        chk("commit_done", 64'(cfg_busy), 64'd0);
    endtask

    initial begin
        // Output-path vectors for map: pins 3,10 <- log2, pin 20 <- log5, pin 49 <- log0.
        vecs[0] = '{6'b000100, 6'b000100, P3_10,                 P3_10};
        vecs[1] = '{6'b100000, 6'b100001, P20,                   P20 | P49};
        vecs[2] = '{6'b111111, 6'b000000, P3_10 | P20 | P49,     50'd0};
        vecs[3] = '{6'b000000, 6'b111111, 50'd0,                 P3_10 | P20 | P49};
        vecs[4] = '{6'b011010, 6'b000010, 50'd0,                 50'd0};
        vecs[5] = '{6'b100101, 6'b100100, P3_10 | P20 | P49,     P3_10 | P20};

        // Reset state, with peripherals trying to drive everything.
        #1;
        chk("rst_async_drv", 64'(physical_drive), 64'd0);
        #22 rst_n = 1'b1;
        tick();
        tick();
        chk("rst_drv", 64'(physical_drive), 64'd0);
        chk("rst_val", 64'(physical_val), 64'd0);
        chk("rst_lin", 64'(logical_in), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);

        // Single mapping through a commit with break-before-make.
        logical_val   = 6'b000100;
        logical_drive = 6'b000100;
        wr(1'b0, 8'd3, 8'd2);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            chk("bbm_busy", 64'(cfg_busy), 64'd1);
            chk("bbm_drv0", 64'(physical_drive), 64'd0);
        end
        tick();
        chk("map_busy_low", 64'(cfg_busy), 64'd0);
        chk("map_drv", 64'(physical_drive), 64'h8);
        chk("map_val", 64'(physical_val), 64'h8);

        // Table-driven output path with fan-out and unmapped/out-of-range entries.
        wr(1'b0, 8'd10, 8'd2);
        wr(1'b0, 8'd20, 8'd5);
        wr(1'b0, 8'd49, 8'd0);
        wr(1'b0, 8'd0,  8'd6);
        wr(1'b0, 8'd1,  8'd200);
        do_commit();
        for (int v = 0; v < 6; v++) begin
            exp_t e;
            logical_val   = vecs[v].lv;
            logical_drive = vecs[v].ld;
            e.val = vecs[v].exp_val;
            e.drv = vecs[v].exp_drv;
            sb_q.push_back(e);
            tick();
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_val", v), 64'(physical_val), 64'(e.val));
            chk($sformatf("vec%0d_drv", v), 64'(physical_drive), 64'(e.drv));
        end

        // Input path latency and out-of-range logical entry.
        wr(1'b1, 8'd1, 8'd7);
        do_commit();
        tick();
        tick();
        tick();
        physical_in[7] = 1'b1;
        tick();
        chk("lin_lat1", 64'(logical_in[1]), 64'd0);
        tick();
        chk("lin_lat2", 64'(logical_in[1]), 64'd0);
        tick();
        chk("lin_lat3", 64'(logical_in[1]), 64'd1);
        physical_in[7] = 1'b0;
        tick();
        tick();
        chk("lin_fall_early", 64'(logical_in[1]), 64'd1);
        tick();
        chk("lin_fall", 64'(logical_in[1]), 64'd0);
        physical_in = {50{1'b1}};
        for (int k = 0; k < 4; k++) tick();
        chk("lin_all_ones", 64'(logical_in), 64'h2);
        wr(1'b1, 8'd1, 8'd60);
        do_commit();
        tick();
        chk("lin_oor_entry", 64'(logical_in), 64'd0);

        // Commit while busy: error pulse, original commit finishes on time.
        cfg_commit = 1'b1;
        tick();
        chk("busy_commit_busy", 64'(cfg_busy), 64'd1);
        tick();
        cfg_commit = 1'b0;
        chk("busy_commit_err", 64'(cfg_err), 64'd1);
        tick();
        chk("busy_commit_err_clr", 64'(cfg_err), 64'd0);
        chk("busy_commit_apply", 64'(cfg_busy), 64'd1);
        tick();
        chk("busy_commit_end", 64'(cfg_busy), 64'd0);

        // Out-of-range writes are dropped and flagged.
        wr(1'b0, 8'd50, 8'd4);
        chk("oor50_err", 64'(cfg_err), 64'd1);
        wr(1'b0, 8'd67, 8'd4);
        chk("oor67_err", 64'(cfg_err), 64'd1);
        wr(1'b1, 8'd6, 8'd4);
        chk("oor_log_err", 64'(cfg_err), 64'd1);
        tick();
        chk("oor_err_clr", 64'(cfg_err), 64'd0);
        // Bad write and busy commit in one cycle give a single pulse.
        cfg_commit = 1'b1;
        tick();
        cfg_wr_en = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = 8'd99;
        tick();
        cfg_commit = 1'b0;
        cfg_wr_en  = 1'b0;
        chk("dual_err", 64'(cfg_err), 64'd1);
        tick();
        chk("dual_err_clr", 64'(cfg_err), 64'd0);
        tick();
        logical_val   = 6'b000100;
        logical_drive = 6'b000100;
        tick();
        chk("oor_no_change", 64'(physical_drive), 64'(P3_10));

        // Remap pin 3 from logical 2 to logical 4 while both drive.
        logical_val   = 6'b010100;
        logical_drive = 6'b010100;
        wr(1'b0, 8'd3, 8'd4);
        chk("remap_before", 64'(physical_drive[3]), 64'd1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            chk("remap_gap", 64'(physical_drive[3]), 64'd0);
        end
        tick();
        chk("remap_after", 64'(physical_drive[3]), 64'd1);
        logical_val   = 6'b000100;
        logical_drive = 6'b000100;
        tick();
        chk("remap_no_old", 64'(physical_drive), 64'h400);

        // Reset in the middle of a commit clears shadow and active maps.
        wr(1'b1, 8'd2, 8'd5);
        do_commit();
        tick();
        chk("pre_rst_lin", 64'(logical_in), 64'h4);
        wr(1'b0, 8'd5, 8'd1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("commit_lin_kept", 64'(logical_in), 64'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_lin", 64'(logical_in), 64'd0);
        chk("midrst_busy", 64'(cfg_busy), 64'd0);
        chk("midrst_drv", 64'(physical_drive), 64'd0);
        #3 rst_n = 1'b1;
        logical_val   = 6'h3F;
        logical_drive = 6'h3F;
        for (int k = 0; k < 4; k++) tick();
        chk("postrst_busy", 64'(cfg_busy), 64'd0);
        chk("postrst_drv", 64'(physical_drive), 64'd0);
        chk("postrst_lin", 64'(logical_in), 64'd0);
        do_commit();
        tick();
        chk("postrst_commit_drv", 64'(physical_drive), 64'd0);
        chk("postrst_commit_lin", 64'(logical_in), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
